seven_segment_capture: RTL and testbench

Observes a multiplexed, active-low seven-segment display bus (segment lines plus digit-select lines) and reconstructs the hex value shown on each digit. It is the inverse of the hex-to-segment decode path, and it lets the board self-check what the display actually shows. It sits between the display pins (looped back) and the debug/register layer. Digit patterns are decoded only after the bus has been stable for a programmable number of cycles, which rejects scan transitions and ghosting.

---
 rtl/seven_segment_capture_if.sv | 35 +++
 rtl/seven_segment_capture.sv | 176 +++++++++++++++++
 tb/tb_seven_segment_capture.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_capture_if.sv
// seven_segment_capture_if
//   Bundles the looped-back display bus and the decoded results of
//   seven_segment_capture.
//   Ports (signals):
//     seg_n       [6:0]          active-low segments, bit0=a .. bit5=f, bit6=g
//     an_n        [NDIGITS-1:0]  active-low digit select
//     digits      [4*NDIGITS-1:0] captured nibbles, digit i at [4i+3:4i]
//     digit_valid [NDIGITS-1:0]  digit i holds a decoded value
//     upd / upd_idx              one-cycle write pulse and written digit index
//     bad / err                  decode-failure pulse and its sticky flag
//   Modports:
//     master - drives the display bus, observes the results
//     slave  - the capture block: observes the bus, drives the results
interface seven_segment_capture_if #(
  parameter int NDIGITS = 4
);
  logic [6:0]           seg_n;
  logic [NDIGITS-1:0]   an_n;
  logic [4*NDIGITS-1:0] digits;
  logic [NDIGITS-1:0]   digit_valid;
  logic                 upd;
  logic [2:0]           upd_idx;
  logic                 bad;
  logic                 err;

  modport master (
    output seg_n, an_n,
    input  digits, digit_valid, upd, upd_idx, bad, err
  );

  modport slave (
    input  seg_n, an_n,
    output digits, digit_valid, upd, upd_idx, bad, err
  );
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Watches a multiplexed active-low seven-segment bus and rebuilds the hex
//   value shown on each digit. A pattern is decoded only once the sampled
//   {an_n, seg_n} word has been identical for STABLE_CYCLES samples, which
//   rejects scan transitions and ghosting. One capture per stable window.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    seven_segment_capture_if.slave (seg_n/an_n in, results out)
//   Parameters:
//     NDIGITS        number of multiplexed digits (1..8)
//     STABLE_CYCLES  identical samples required before capture (2..255)
//   Build option:
//     SEVENSEG_CAPTURE_SYNC_EN  when defined, the inputs pass through a
//     two-flop synchronizer (one extra cycle of latency); otherwise they are
//     registered once and assumed synchronous to clk.
module seven_segment_capture #(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    reset,
  seven_segment_capture_if.slave bus
);

  localparam int W = NDIGITS + 7;
`ifdef SEVENSEG_CAPTURE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [7:0] LAST   = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  logic [S-1:0][W-1:0] stage_reg;
  logic [W-1:0]        smp;
  logic [W-1:0]        prev_reg;
  state_t              state_reg;
  logic [7:0]          cnt_reg;
  logic [7:0]          cnt_inc;
  logic [NDIGITS-1:0]  sel;
  logic                sel_onehot;
  logic [2:0]          sel_idx;
  logic                same;
  logic [4:0]          dec;
  logic                cap_fire;
  logic                cap_hit;
  logic                upd_reg;
  logic                bad_reg;
  logic                err_reg;
  logic [2:0]          upd_idx_reg;

  // Returns {hit, nibble} for a true-high segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h67:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  // Input staging; reset loads all-ones so nothing appears selected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '1;
    end else begin
      stage_reg[0] <= {bus.an_n, bus.seg_n};
      for (int i = 1; i < S; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign smp        = stage_reg[S-1];
  assign sel        = ~smp[W-1:7];
  assign sel_onehot = (sel != '0) && ((sel & (sel - NDIGITS'(1))) == '0);
  assign same       = (smp == prev_reg);
  assign cnt_inc    = (cnt_reg == STABLE) ? cnt_reg : cnt_reg + 8'd1;
  assign dec        = decode(~smp[6:0]);
  assign cap_hit    = dec[4];

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (sel[i]) sel_idx = 3'(i);
    end
  end

  // cnt_inc reaching STABLE_CYCLES-1 means the current sample is the
  // STABLE_CYCLES-th identical one. A change on this edge makes same=0,
  // so a change always beats a capture.
  assign cap_fire = sel_onehot && same && (state_reg == SETTLE) && (cnt_inc == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg    <= '1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      upd_reg     <= 1'b0;
      bad_reg     <= 1'b0;
      err_reg     <= 1'b0;
      upd_idx_reg <= '0;
    end else begin
      prev_reg <= smp;
      upd_reg  <= 1'b0;
      bad_reg  <= 1'b0;
      if (!sel_onehot) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else if (!same) begin
        state_reg <= SETTLE;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_inc;
        case (state_reg)
          IDLE:   state_reg <= SETTLE;
          SETTLE: begin
            if (cap_fire) begin
              state_reg <= HELD;
              upd_reg   <= cap_hit;
              bad_reg   <= !cap_hit;
              err_reg   <= err_reg | !cap_hit;
              if (cap_hit) upd_idx_reg <= sel_idx;
            end
          end
          HELD:    state_reg <= HELD;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Per-digit storage. A failed decode keeps the old nibble but drops valid.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [3:0] nib_reg;
      logic       valid_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          nib_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (cap_fire && (sel_idx == 3'(gi))) begin
          valid_reg <= cap_hit;
          if (cap_hit) nib_reg <= dec[3:0];
        end
      end

      assign bus.digits[4*gi +: 4] = nib_reg;
      assign bus.digit_valid[gi]   = valid_reg;
    end
  endgenerate

  assign bus.upd     = upd_reg;
  assign bus.upd_idx = upd_idx_reg;
  assign bus.bad     = bad_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
//   Directed steps followed by a randomized phase. The reference model keeps
//   a history of sampled {an_n, seg_n} words and declares a capture when the
//   newest STABLE_CYCLES samples are identical, one-hot, and preceded by a
//   different sample. Outputs are checked #1 after every rising edge.
module tb_seven_segment_capture;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int W  = ND + 7;
`ifdef SEVENSEG_CAPTURE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_segment_capture_if #(.NDIGITS(ND)) bus ();

  seven_segment_capture #(
    .NDIGITS      (ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state
  logic [W-1:0]    raw_hist [$];
  logic [W-1:0]    smp_hist [$];
  logic [4*ND-1:0] exp_digits;
  logic [ND-1:0]   exp_valid;
  logic            exp_upd, exp_bad, exp_err;
  logic [2:0]      exp_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    chk("digits", 32'(bus.digits), 32'(exp_digits));
    chk("digit_valid", 32'(bus.digit_valid), 32'(exp_valid));
    chk("upd", 32'(bus.upd), 32'(exp_upd));
    chk("bad", 32'(bus.bad), 32'(exp_bad));
    chk("err", 32'(bus.err), 32'(exp_err));
    if (exp_upd) chk("upd_idx", 32'(bus.upd_idx), 32'(exp_idx));
  endtask

  task automatic model_clear();
    raw_hist.delete();
    smp_hist.delete();
    for (int i = 0; i < S; i++) raw_hist.push_front('1);
    for (int i = 0; i <= SC; i++) smp_hist.push_front('1);
    exp_digits = '0; exp_valid = '0; exp_upd = 1'b0;
    exp_bad = 1'b0; exp_err = 1'b0; exp_idx = '0;
  endtask

  task automatic model_capture(input logic [W-1:0] s);
    logic [6:0]    p;
    logic [ND-1:0] an;
    int            d, v;
    p  = ~s[6:0];
    an = s[W-1:7];
    d  = 0;
    v  = -1;
    for (int i = 0; i < ND; i++) if (!an[i]) d = i;
    for (int k = 0; k < 16; k++) if (pat[k] == p) v = k;
    if (v >= 0) begin
      exp_digits[4*d +: 4] = 4'(v);
      exp_valid[d] = 1'b1;
      exp_upd = 1'b1;
      exp_idx = 3'(d);
    end else begin
      exp_valid[d] = 1'b0;
      exp_bad = 1'b1;
      exp_err = 1'b1;
    end
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin
      model_clear();
      #1;
      check_outputs();
    end
  endtask

  task automatic tick();
    logic [W-1:0]  raw, s, newest;
    logic [ND-1:0] sel;
    bit            fire;
    @(posedge clk);
    exp_upd = 1'b0;
    exp_bad = 1'b0;
    if (reset) begin
      raw = '1;
    end else begin
      raw    = {bus.an_n, bus.seg_n};
      newest = smp_hist[0];
      sel    = ~newest[W-1:7];
      fire   = ($countones(sel) == 1) && (smp_hist[SC] != newest);
      for (int j = 1; j < SC; j++) if (smp_hist[j] != newest) fire = 0;
      if (fire) model_capture(newest);
    end
    raw_hist.push_front(raw);
    void'(raw_hist.pop_back());
    s = reset ? '1 : raw_hist[S-1];
    smp_hist.push_front(s);
    void'(smp_hist.pop_back());
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) tick();
  endtask

  initial begin
    int   n;
    bit   seen;
    logic [ND-1:0] an;
    logic [6:0]    seg;

    bus.an_n  = '1;
    bus.seg_n = '1;
    set_reset(1'b1);

    // Reset held with inputs toggling
    repeat (3) begin
      bus.an_n  = ND'($urandom);
      bus.seg_n = 7'($urandom);
      tick();
    end
    bus.an_n  = '1;
    bus.seg_n = '1;
    set_reset(1'b0);
    tick();

    // Single digit: latency from the input change to upd
    bus.an_n  = 4'b1110;
    bus.seg_n = ~pat[0];
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.upd) seen = 1;
    end
    chk("latency", 32'(n), 32'(S + SC));
    if (n < 10) repeat (10 - n) tick();
    chk("single_valid", 32'(bus.digit_valid), 32'h1);

    // Scan 1,2,3,F across digits 0..3
    hold(4'b1110, ~pat[1], 6);
    hold(4'b1101, ~pat[2], 6);
    hold(4'b1011, ~pat[3], 6);
    hold(4'b0111, ~pat[15], 6);
    tick();
    chk("scan_digits", 32'(bus.digits), 32'hF321);
    chk("scan_valid", 32'(bus.digit_valid), 32'hF);

    // Glitch window and multi-select
    hold(4'b1101, ~pat[5], 3);
    hold(4'b1100, ~pat[5], 8);
    chk("glitch_digits", 32'(bus.digits), 32'hF321);

    // Invalid (blank) pattern after a good capture on digit 2
    hold(4'b1011, ~pat[5], S + SC);
    hold(4'b1011, 7'h7F, 6);
    chk("invalid_err", 32'(bus.err), 32'h1);
    chk("invalid_valid2", 32'(bus.digit_valid[2]), 32'h0);
    chk("invalid_nib2", 32'(bus.digits[11:8]), 32'h5);

    // Reset in the middle of a settling window
    hold(4'b1110, ~pat[6], S + 2);
    set_reset(1'b1);
    tick();
    set_reset(1'b0);
    repeat (S + SC + 2) tick();
    chk("post_reset_valid", 32'(bus.digit_valid), 32'h1);

    // Randomized scan with occasional bad patterns, multi-selects and resets
    for (int t = 0; t < 300; t++) begin
      n = int'($urandom_range(0, 9));
      if (n < 8)       an = ~(ND'(1) << $urandom_range(0, ND - 1));
      else if (n == 8) an = '1;
      else             an = ND'($urandom);
      if ($urandom_range(0, 4) != 0) seg = ~pat[$urandom_range(0, 15)];
      else                           seg = 7'($urandom);
      hold(an, seg, int'($urandom_range(1, 8)));
      if ($urandom_range(0, 29) == 0) begin
        set_reset(1'b1);
        tick();
        set_reset(1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
